// File: rtl/ysyx_22040237_idu_stage.sv
// ysyx_22040237_idu_stage: decode stage between IFU and EXU with a RAW scoreboard
// and a halt latch for EBREAK/invalid encodings.
module ysyx_22040237_idu_stage #(
  parameter int XLEN = 64,
  parameter int PCW = 32,
  parameter logic [7:0] OP_NOP = 8'h00,
  parameter logic [7:0] OP_ADD = 8'h01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [PCW-1:0]  if_pc,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [7:0]      inst_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [PCW-1:0]  op1_jump,
  output logic [PCW-1:0]  op2_jump,
  output logic            is_jump,
  output logic [4:0]      rd_addr,
  output logic            rd_wen,
  output logic            inst_ebreak,
  output logic            invalid_inst
);
  logic [31:0] inst;
  logic [PCW-1:0] pc;
  logic stage_valid, halted;
  logic [31:0] sb, sb_set, sb_clr;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_addi, is_add, is_lui, is_auipc, is_jal, is_jalr, is_ebreak, is_valid;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, pc_x, d_op1, d_op2;
  logic [PCW-1:0] d_op1_jump, d_op2_jump;
  logic uses_rs1, uses_rs2, raw1, raw2, hazard, issue, load, d_wen;
  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign is_addi = opc == 7'b0010011 && f3 == 3'b000;
  assign is_add = opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000;
  assign is_lui = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111 && f3 == 3'b000;
  assign is_ebreak = inst == 32'h00100073;
  assign is_valid = is_addi || is_add || is_lui || is_auipc || is_jal || is_jalr;
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign pc_x = {{(XLEN-PCW){1'b0}}, pc};
  always_comb begin
    d_op1 = (is_addi || is_add) ? rs1_data : (is_auipc || is_jal || is_jalr) ? pc_x : '0;
    d_op2 = is_addi ? imm_i : is_add ? rs2_data : (is_lui || is_auipc) ? imm_u :
            (is_jal || is_jalr) ? XLEN'(4) : '0;
    d_op1_jump = is_jal ? pc : is_jalr ? rs1_data[PCW-1:0] : '0;
    d_op2_jump = is_jal ? imm_j[PCW-1:0] : is_jalr ? imm_i[PCW-1:0] : '0;
  end
  assign d_wen = is_valid && inst[11:7] != 5'd0;
  // A source is busy if its result is still outstanding or sits unaccepted in the output register
  assign uses_rs1 = is_addi || is_add || is_jalr;
  assign uses_rs2 = is_add;
  assign raw1 = uses_rs1 && rs1_addr != 5'd0 &&
                (sb[rs1_addr] || (ex_valid && rd_wen && rd_addr == rs1_addr));
  assign raw2 = uses_rs2 && rs2_addr != 5'd0 &&
                (sb[rs2_addr] || (ex_valid && rd_wen && rd_addr == rs2_addr));
  assign hazard = raw1 || raw2;
  assign issue = stage_valid && !halted && !flush && !hazard && (!ex_valid || ex_ready);
  assign if_ready = !halted && (!stage_valid || issue);
  assign load = if_valid && if_ready && !flush;
  assign sb_set = (ex_valid && ex_ready && rd_wen && !flush) ? (32'd1 << rd_addr) : 32'd0;
  assign sb_clr = wb_valid ? (32'd1 << wb_rd) : 32'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst <= '0;
      pc <= '0;
      stage_valid <= 1'b0;
      halted <= 1'b0;
      sb <= '0;
      ex_valid <= 1'b0;
      inst_opcode <= OP_NOP;
      op1 <= '0;
      op2 <= '0;
      op1_jump <= '0;
      op2_jump <= '0;
      is_jump <= 1'b0;
      rd_addr <= '0;
      rd_wen <= 1'b0;
      inst_ebreak <= 1'b0;
      invalid_inst <= 1'b0;
    end else begin
      sb <= ((sb & ~sb_clr) | sb_set) & ~32'd1;
      if (issue && !is_valid) halted <= 1'b1;
      stage_valid <= (flush || halted) ? 1'b0 : load ? 1'b1 : issue ? 1'b0 : stage_valid;
      if (load) begin
        inst <= if_inst;
        pc <= if_pc;
      end
      ex_valid <= flush ? 1'b0 : issue ? 1'b1 : ex_ready ? 1'b0 : ex_valid;
      if (issue) begin
        inst_opcode <= is_valid ? OP_ADD : OP_NOP;
        op1 <= d_op1;
        op2 <= d_op2;
        op1_jump <= d_op1_jump;
        op2_jump <= d_op2_jump;
        is_jump <= is_jal || is_jalr;
        rd_addr <= inst[11:7];
        rd_wen <= d_wen;
        inst_ebreak <= is_ebreak;
        invalid_inst <= !is_valid && !is_ebreak;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040237_idu_stage.sv
// tb_ysyx_22040237_idu_stage: directed checks of hazards, backpressure, flush, halt and reset.
module tb_ysyx_22040237_idu_stage;
  logic clk = 1'b0;
  logic rst, if_valid, if_ready, flush, wb_valid, ex_valid, ex_ready;
  logic [31:0] if_inst, if_pc, op1_jump, op2_jump;
  logic [4:0] rs1_addr, rs2_addr, wb_rd, rd_addr;
  logic [63:0] rs1_data, rs2_data, op1, op2;
  logic [7:0] inst_opcode;
  logic is_jump, rd_wen, inst_ebreak, invalid_inst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // register file model: xN reads as N*0x1111
  assign rs1_data = {59'd0, rs1_addr} * 64'h1111;
  assign rs2_data = {59'd0, rs2_addr} * 64'h1111;

  ysyx_22040237_idu_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .inst_opcode(inst_opcode), .op1(op1), .op2(op2),
    .op1_jump(op1_jump), .op2_jump(op2_jump), .is_jump(is_jump), .rd_addr(rd_addr),
    .rd_wen(rd_wen), .inst_ebreak(inst_ebreak), .invalid_inst(invalid_inst)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; ex_ready = 1'b1;
    step(); step();
    chk("rst_ex_valid", 64'(ex_valid), 0);
    chk("rst_opcode", 64'(inst_opcode), 0);
    chk("rst_op1", op1, 0);
    chk("rst_rd_wen", 64'(rd_wen), 0);
    chk("rst_if_ready", 64'(if_ready), 1);
    rst = 1'b1;
    // ADDI x1,x0,5 followed by dependent ADD x2,x1,x1
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h100;
    chk("addi_if_ready", 64'(if_ready), 1);
    step();
    if_inst = 32'h00108133; if_pc = 32'h104;
    chk("addi_rs1_addr", 64'(rs1_addr), 0);
    chk("addi_issue_ready", 64'(if_ready), 1);
    step();
    if_valid = 1'b0;
    chk("addi_ex_valid", 64'(ex_valid), 1);
    chk("addi_opcode", 64'(inst_opcode), 64'h01);
    chk("addi_op1", op1, 0);
    chk("addi_op2", op2, 5);
    chk("addi_rd_addr", 64'(rd_addr), 1);
    chk("addi_rd_wen", 64'(rd_wen), 1);
    chk("add_stall_exreg", 64'(if_ready), 0);
    step();
    chk("addi_drop", 64'(ex_valid), 0);
    chk("add_stall_sb", 64'(if_ready), 0);
    step(); step();
    chk("add_stall_sb2", 64'(if_ready), 0);
    wb_valid = 1'b1; wb_rd = 5'd1;
    step();
    wb_valid = 1'b0;
    chk("add_not_yet", 64'(ex_valid), 0);
    chk("add_release", 64'(if_ready), 1);
    step();
    chk("add_ex_valid", 64'(ex_valid), 1);
    chk("add_op1", op1, 64'h1111);
    chk("add_op2", op2, 64'h1111);
    chk("add_rd_addr", 64'(rd_addr), 2);
    // set and clear of x2 in the same cycle: set wins
    wb_valid = 1'b1; wb_rd = 5'd2;
    step();
    wb_valid = 1'b0; if_valid = 1'b1; if_inst = 32'h00110193; if_pc = 32'h108;
    chk("add_drop", 64'(ex_valid), 0);
    step();
    if_valid = 1'b0;
    chk("set_wins_stall", 64'(if_ready), 0);
    step();
    chk("set_wins_held", 64'(ex_valid), 0);
    wb_valid = 1'b1; wb_rd = 5'd2;
    step();
    wb_valid = 1'b0;
    chk("set_wins_release", 64'(if_ready), 1);
    step();
    chk("addi3_ex_valid", 64'(ex_valid), 1);
    chk("addi3_op1", op1, 64'h2222);
    chk("addi3_op2", op2, 1);
    chk("addi3_rd", 64'(rd_addr), 3);
    step();
    wb_valid = 1'b1; wb_rd = 5'd3;
    step();
    wb_valid = 1'b0;
    // JAL x1,+16
    if_valid = 1'b1; if_inst = 32'h010000EF; if_pc = 32'h80000000;
    step();
    if_valid = 1'b0;
    step();
    chk("jal_op1", op1, 64'h80000000);
    chk("jal_op2", op2, 4);
    chk("jal_op1_jump", 64'(op1_jump), 64'h80000000);
    chk("jal_op2_jump", 64'(op2_jump), 16);
    chk("jal_is_jump", 64'(is_jump), 1);
    chk("jal_rd_wen", 64'(rd_wen), 1);
    step();
    wb_valid = 1'b1; wb_rd = 5'd1;
    step();
    wb_valid = 1'b0;
    // backpressure: LUI x5 then AUIPC x6 while EXU stalls
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h123452B7; if_pc = 32'h1F0;
    step();
    if_inst = 32'h00001317; if_pc = 32'h200;
    step();
    if_valid = 1'b0;
    chk("lui_ex_valid", 64'(ex_valid), 1);
    chk("lui_op1", op1, 0);
    chk("lui_op2", op2, 64'h12345000);
    chk("lui_rd", 64'(rd_addr), 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ex_valid", 64'(ex_valid), 1);
      chk("bp_op2_stable", op2, 64'h12345000);
      chk("bp_if_ready", 64'(if_ready), 0);
    end
    ex_ready = 1'b1;
    step();
    chk("auipc_ex_valid", 64'(ex_valid), 1);
    chk("auipc_op1", op1, 64'h200);
    chk("auipc_op2", op2, 64'h1000);
    chk("auipc_rd", 64'(rd_addr), 6);
    step();
    chk("bp_no_dup", 64'(ex_valid), 0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    step();
    wb_rd = 5'd6;
    step();
    wb_valid = 1'b0;
    // flush with both registers occupied
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h00700393; if_pc = 32'h300;
    step();
    if_inst = 32'h00800413; if_pc = 32'h304;
    step();
    if_valid = 1'b0;
    chk("fl_ex_valid", 64'(ex_valid), 1);
    chk("fl_rd", 64'(rd_addr), 7);
    chk("fl_if_ready", 64'(if_ready), 0);
    flush = 1'b1; ex_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ex_cleared", 64'(ex_valid), 0);
    chk("fl_stage_cleared", 64'(if_ready), 1);
    if_valid = 1'b1; if_inst = 32'h008384B3; if_pc = 32'h308;
    step();
    if_valid = 1'b0;
    chk("fl_no_sb", 64'(if_ready), 1);
    step();
    chk("add9_ex_valid", 64'(ex_valid), 1);
    chk("add9_op1", op1, 64'h7777);
    chk("add9_op2", op2, 64'h8888);
    chk("add9_rd", 64'(rd_addr), 9);
    step();
    // stall on x9, then asynchronous reset mid-stall
    if_valid = 1'b1; if_inst = 32'h00048513; if_pc = 32'h30C;
    step();
    if_valid = 1'b0;
    chk("x9_stall", 64'(if_ready), 0);
    step();
    chk("x9_held", 64'(ex_valid), 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_ex_valid", 64'(ex_valid), 0);
    chk("arst_op1", op1, 0);
    chk("arst_op2", op2, 0);
    chk("arst_rd_addr", 64'(rd_addr), 0);
    chk("arst_rd_wen", 64'(rd_wen), 0);
    chk("arst_opcode", 64'(inst_opcode), 0);
    chk("arst_rs1_addr", 64'(rs1_addr), 0);
    chk("arst_if_ready", 64'(if_ready), 1);
    step();
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd9; if_valid = 1'b1;
    step();
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("post_rst_no_hazard", 64'(if_ready), 1);
    step();
    chk("x10_ex_valid", 64'(ex_valid), 1);
    chk("x10_op1", op1, 64'h9999);
    chk("x10_rd", 64'(rd_addr), 10);
    step();
    // EBREAK halts; the instruction loaded behind it is discarded
    if_valid = 1'b1; if_inst = 32'h00100073; if_pc = 32'h400;
    step();
    if_inst = 32'h00500093; if_pc = 32'h404;
    chk("ebr_accept_next", 64'(if_ready), 1);
    step();
    if_valid = 1'b0;
    chk("ebr_flag", 64'(inst_ebreak), 1);
    chk("ebr_rd_wen", 64'(rd_wen), 0);
    chk("ebr_opcode", 64'(inst_opcode), 0);
    chk("ebr_ex_valid", 64'(ex_valid), 1);
    chk("ebr_invalid", 64'(invalid_inst), 0);
    chk("ebr_halted", 64'(if_ready), 0);
    step();
    chk("ebr_discard", 64'(ex_valid), 0);
    step(); step();
    chk("ebr_discard2", 64'(ex_valid), 0);
    chk("ebr_halted2", 64'(if_ready), 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    // invalid encoding
    if_valid = 1'b1; if_inst = 32'hFFFFFFFF; if_pc = 32'h500;
    step();
    if_valid = 1'b0;
    step();
    chk("inv_flag", 64'(invalid_inst), 1);
    chk("inv_opcode", 64'(inst_opcode), 0);
    chk("inv_op1", op1, 0);
    chk("inv_op2", op2, 0);
    chk("inv_rd_wen", 64'(rd_wen), 0);
    chk("inv_ebreak", 64'(inst_ebreak), 0);
    chk("inv_ex_valid", 64'(ex_valid), 1);
    step();
    chk("inv_halted", 64'(if_ready), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
